// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  // IDLE: waiting for start bit, DATA: shifting 8 bits, PARITY: capturing parity, STOP: checking stop bit
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] PS2_PREFIX_EXT     = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK     = 8'hF0;
  localparam int         PS2_TIMEOUT_CYCLES = 10000;

  typedef struct packed {
    logic [7:0] code;
    logic       extended;
    logic       brk;
  } key_event_t;

  function automatic logic parity_ok(input logic [7:0] b, input logic p);
    return (^b) ^ p;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the raw PS/2 clock and data pins into the clock50 domain and flags clock falling edges.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock50,
  input  logic reset,
  input  logic ps2Clk,
  input  logic ps2Data,
  output logic clk_fall,
  output logic data_s
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // Reset to the idle bus level so releasing reset never fakes a falling edge.
  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2Clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2Data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign clk_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_rx_sequencer.sv
// PS/2 frame receiver in the clock50 domain: frame FSM with timeout, E0/F0 prefix folding,
// and a valid/ready holding register for key events.
module ps2_rx_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_break,
  output logic       frame_error,
  output logic       overflow,
  output logic       busy
);

  localparam int              TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_TC = TO_W'(TIMEOUT_CYCLES - 1);

  logic            clk_fall;
  logic            data_s;
  frame_state_e    state_q;
  logic [3:0]      bitcnt_q;
  logic [7:0]      sh_q;
  logic            par_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [7:0]      byte_q;
  logic            byte_vld_q;
  logic            frame_error_q;
  logic            ext_q;
  logic            brk_q;
  key_event_t      evt_q;
  logic            key_valid_q;
  logic            overflow_q;
  key_event_t      evt_d;
  logic            evt_fire;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock50  (clock50),
    .reset    (reset),
    .ps2Clk   (ps2Clk),
    .ps2Data  (ps2Data),
    .clk_fall (clk_fall),
    .data_s   (data_s)
  );

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      sh_q          <= '0;
      par_q         <= 1'b0;
      to_cnt_q      <= '0;
      byte_q        <= '0;
      byte_vld_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      byte_vld_q    <= 1'b0;
      frame_error_q <= 1'b0;
      if (state_q == ST_IDLE || clk_fall)
        to_cnt_q <= '0;
      else if (to_cnt_q != TO_TC)
        to_cnt_q <= to_cnt_q + TO_W'(1);
      // An edge in the terminal-count cycle still advances the frame.
      if (clk_fall) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_s) begin
              state_q  <= ST_DATA;
              bitcnt_q <= '0;
            end
          end
          ST_DATA: begin
            sh_q     <= {data_s, sh_q[7:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= data_s;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            state_q <= ST_IDLE;
            if (parity_ok(sh_q, par_q) && data_s) begin
              byte_q     <= sh_q;
              byte_vld_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE && to_cnt_q == TO_TC) begin
        state_q       <= ST_IDLE;
        frame_error_q <= 1'b1;
      end
    end
  end

  assign evt_d    = '{code: byte_q, extended: ext_q, brk: brk_q};
  assign evt_fire = byte_vld_q && (byte_q != PS2_PREFIX_EXT) && (byte_q != PS2_PREFIX_BRK);

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      evt_q       <= '0;
      key_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (frame_error_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_vld_q) begin
        if (byte_q == PS2_PREFIX_EXT) begin
          ext_q <= 1'b1;
        end else if (byte_q == PS2_PREFIX_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
      // A held event that is not being taken blocks the new one.
      if (evt_fire) begin
        if (!key_valid_q || key_ready) begin
          evt_q       <= evt_d;
          key_valid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = evt_q.code;
  assign key_extended = evt_q.extended;
  assign key_break    = evt_q.brk;
  assign frame_error  = frame_error_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
